m_dm_arb: RTL and testbench

Data-memory port arbiter for the M stage. Shares the single synchronous data memory port between the CPU M-stage access (byte enables and lane-aligned write data already produced by the store byte-enable logic) and a DMA/bridge requester. The CPU has priority, with locked DMA bursts and an optional starvation guard. It drives the DM port, stalls the CPU when the CPU loses arbitration, and routes the one-cycle-late read data back to the owner.

---
 rtl/m_dm_arb_pkg.sv | 20 ++
 rtl/m_dm_arb_starve.sv | 48 ++++
 rtl/m_dm_arb.sv | 189 ++++++++++++++++++
 tb/tb_m_dm_arb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_dm_arb_pkg.sv
// m_dm_arb_pkg
// Shared encodings for the data-memory port arbiter.
//   arb_state_e : arbiter FSM states (arb_s_arb / arb_s_burst)
//   arb_own_*   : owner encodings stored with an outstanding read
//   word_addr() : byte address to word-aligned DM address
package m_dm_arb_pkg;

    typedef enum logic {
        arb_s_arb   = 1'b0,
        arb_s_burst = 1'b1
    } arb_state_e;

    localparam logic arb_own_cpu = 1'b0;
    localparam logic arb_own_dma = 1'b1;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/m_dm_arb_starve.sv
// m_dm_arb_starve
// Starvation counter for the DM arbiter. Counts contested cycles the CPU won,
// saturating at STARVE_LIMIT; 'fire' tells the arbiter to let the DMA through.
// Only instantiated when DM_ARB_STARVE_EN is defined.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   clr   : clear the counter (DMA granted or DMA not requesting)
//   inc   : contested cycle won by the CPU
//   fire  : counter has reached STARVE_LIMIT
module m_dm_arb_starve
    import m_dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic fire
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // The counter holds once it reaches the limit so the guard stays armed
    // until the DMA actually gets the port (a post-burst priority cycle can
    // delay it by one cycle).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != 4'(STARVE_LIMIT))) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    assign fire = (cnt_q == 4'(STARVE_LIMIT));

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/m_dm_arb.sv
// m_dm_arb
// Data-memory port arbiter for the M stage. The CPU has priority; a DMA
// requester can lock the port for bursts of up to MAX_BURST beats. The grant
// is combinational, the DM port is a mux of the owner's signals, and read
// data returning one cycle later is tagged for its owner via cpu_rvalid /
// dma_rvalid.
// Optional feature macro: DM_ARB_STARVE_EN (starvation guard that forces a
// DMA access through after STARVE_LIMIT contested CPU wins).
// Ports:
//   clk, reset                  : clock / synchronous active-low reset
//   cpu_req/byteen/addr/wdata   : CPU M-stage access (byteen 0 = read)
//   cpu_stall, cpu_rvalid       : CPU lost arbitration / CPU read data valid
//   dma_req/lock/byteen/addr/wdata : DMA access, lock keeps the port
//   dma_gnt, dma_rvalid         : DMA accepted / DMA read data valid
//   dm_en/byteen/addr/wdata     : data-memory port
//   dm_rdata, rdata             : DM read data and its pass-through
module m_dm_arb
    import m_dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [3:0]  cpu_byteen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic [3:0]  dma_byteen,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic        dm_en,
    output logic [3:0]  dm_byteen,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic [31:0] rdata
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic [4:0] beat_q;
    logic [4:0] beat_d;
    logic       prio_q;
    logic       prio_d;
    logic       rd_vld_q;
    logic       rd_vld_d;
    logic       rd_own_q;
    logic       rd_own_d;

    logic       cpu_gnt;
    logic       dma_gnt_c;
    logic       starve_fire;
    logic       addr_lsb_unused;

    assign addr_lsb_unused = ^{cpu_addr[1:0], dma_addr[1:0]};

`ifdef DM_ARB_STARVE_EN
    logic starve_clr;
    logic starve_inc;

    // The guard only sees contested ARB cycles; any DMA grant or an idle DMA
    // side resets it.
    assign starve_inc = (state_q == arb_s_arb) && cpu_req && dma_req && cpu_gnt;
    assign starve_clr = !dma_req || dma_gnt_c;

    m_dm_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr   (starve_clr),
        .inc   (starve_inc),
        .fire  (starve_fire)
    );
`else
    assign starve_fire = 1'b0;
`endif

    // Grant decision. In BURST the DMA owns the port outright. In ARB the CPU
    // wins a contest unless the starvation guard fires, and the guard is
    // ignored in the cycle right after a burst so the CPU always gets in.
    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt_c = 1'b0;
        if (state_q == arb_s_burst) begin
            dma_gnt_c = dma_req;
        end else if (cpu_req && dma_req) begin
            if (starve_fire && !prio_q) begin
                dma_gnt_c = 1'b1;
            end else begin
                cpu_gnt = 1'b1;
            end
        end else begin
            cpu_gnt   = cpu_req;
            dma_gnt_c = dma_req;
        end
    end

    // Next-state logic. beat counts granted beats of the current burst; the
    // beat that brings it to MAX_BURST is the last one. Every burst exit
    // arms the one-cycle CPU-priority flag.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        prio_d  = 1'b0;
        case (state_q)
            arb_s_arb: begin
                if (dma_gnt_c && dma_lock) begin
                    if (MAX_BURST > 1) begin
                        state_d = arb_s_burst;
                        beat_d  = 5'd1;
                    end else begin
                        prio_d  = 1'b1;
                    end
                end
            end
            arb_s_burst: begin
                if (!dma_req || !dma_lock || (beat_q == 5'(MAX_BURST - 1))) begin
                    state_d = arb_s_arb;
                    beat_d  = 5'd0;
                    prio_d  = 1'b1;
                end else begin
                    beat_d  = beat_q + 5'd1;
                end
            end
            default: begin
                state_d = arb_s_arb;
                beat_d  = 5'd0;
            end
        endcase
    end

    // Record who issued a read this cycle so the returning data can be
    // tagged next cycle. Writes leave rd_vld low.
    always_comb begin
        rd_vld_d = (cpu_gnt && (cpu_byteen == 4'b0000)) ||
                   (dma_gnt_c && (dma_byteen == 4'b0000));
        rd_own_d = dma_gnt_c ? arb_own_dma : arb_own_cpu;
    end

    // All arbiter state with synchronous active-low reset; a reset mid-burst
    // discards the burst and the read in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= arb_s_arb;
            beat_q   <= 5'd0;
            prio_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_own_q <= arb_own_cpu;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            prio_q   <= prio_d;
            rd_vld_q <= rd_vld_d;
            rd_own_q <= rd_own_d;
        end
    end

    // DM port mux: the granted owner drives it, otherwise the port is idle.
    always_comb begin
        dm_en     = cpu_gnt || dma_gnt_c;
        dm_byteen = 4'b0000;
        dm_addr   = 32'd0;
        dm_wdata  = 32'd0;
        if (dma_gnt_c) begin
            dm_byteen = dma_byteen;
            dm_addr   = word_addr(dma_addr);
            dm_wdata  = dma_wdata;
        end else if (cpu_gnt) begin
            dm_byteen = cpu_byteen;
            dm_addr   = word_addr(cpu_addr);
            dm_wdata  = cpu_wdata;
        end
    end

    assign cpu_stall  = cpu_req && !cpu_gnt;
    assign dma_gnt    = dma_gnt_c;
    assign cpu_rvalid = rd_vld_q && (rd_own_q == arb_own_cpu);
    assign dma_rvalid = rd_vld_q && (rd_own_q == arb_own_dma);
    assign rdata      = dm_rdata;

endmodule

// File: tb/tb_m_dm_arb.sv
// tb_m_dm_arb
// Testbench for m_dm_arb (STARVE_LIMIT=4, MAX_BURST=8). Directed scenarios
// followed by randomized traffic, all compared against a cycle-level
// reference model of the arbitration rules. Honours DM_ARB_STARVE_EN.
module tb_m_dm_arb;

    localparam int LIMIT = 4;
    localparam int MAXB  = 8;
`ifdef DM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    typedef struct {
        logic        rst_n;
        logic        c_req;
        logic [3:0]  c_be;
        logic [31:0] c_ad;
        logic [31:0] c_wd;
        logic        d_req;
        logic        d_lock;
        logic [3:0]  d_be;
        logic [31:0] d_ad;
        logic [31:0] d_wd;
        logic [31:0] rd;
    } stim_t;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic        dma_req;
    logic        dma_lock;
    logic [3:0]  dma_byteen;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic        dm_en;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [31:0] rdata;

    int checks;
    int failures;

    // Reference model state: burst ownership, beats taken, contested CPU
    // wins, the post-burst CPU-priority cycle, and the pending read owner
    // (0 none, 1 CPU, 2 DMA).
    bit m_burst;
    int m_beats;
    int m_starve;
    bit m_cpu_first;
    int m_pend;

    logic        snap_stall;
    logic        snap_dgnt;
    logic        snap_en;
    logic [31:0] snap_addr;
    logic [3:0]  snap_be;
    logic        snap_crv;
    logic        snap_drv;
    logic [31:0] snap_rdata;

    m_dm_arb #(
        .STARVE_LIMIT (LIMIT),
        .MAX_BURST    (MAXB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_byteen (cpu_byteen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_lock   (dma_lock),
        .dma_byteen (dma_byteen),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dm_en      (dm_en),
        .dm_byteen  (dm_byteen),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .rdata      (rdata)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic stim_t mk(input bit rst_n, input bit cr, input logic [3:0] cbe,
                                 input logic [31:0] ca, input bit dr, input bit dl,
                                 input logic [3:0] dbe, input logic [31:0] da,
                                 input logic [31:0] rd);
        stim_t s;
        s.rst_n  = rst_n;
        s.c_req  = cr;
        s.c_be   = cbe;
        s.c_ad   = ca;
        s.c_wd   = $urandom;
        s.d_req  = dr;
        s.d_lock = dl;
        s.d_be   = dbe;
        s.d_ad   = da;
        s.d_wd   = $urandom;
        s.rd     = rd;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        reset      = s.rst_n;
        cpu_req    = s.c_req;
        cpu_byteen = s.c_be;
        cpu_addr   = s.c_ad;
        cpu_wdata  = s.c_wd;
        dma_req    = s.d_req;
        dma_lock   = s.d_lock;
        dma_byteen = s.d_be;
        dma_addr   = s.d_ad;
        dma_wdata  = s.d_wd;
        dm_rdata   = s.rd;
    endtask

    // Advance the reference model across one clock edge.
    task automatic modelStep(input stim_t s, input bit gc, input bit gd);
        bit cpu_won_contest;
        if (!s.rst_n) begin
            m_burst     = 1'b0;
            m_beats     = 0;
            m_starve    = 0;
            m_cpu_first = 1'b0;
            m_pend      = 0;
            return;
        end
        cpu_won_contest = !m_burst && s.c_req && s.d_req && gc;
        if (!s.d_req || gd) m_starve = 0;
        else if (cpu_won_contest && m_starve < LIMIT) m_starve++;
        m_pend = (gc && s.c_be == 4'b0) ? 1 : ((gd && s.d_be == 4'b0) ? 2 : 0);
        if (m_burst) begin
            if (gd) m_beats++;
            if (!gd || !s.d_lock || m_beats >= MAXB) begin
                m_burst     = 1'b0;
                m_beats     = 0;
                m_cpu_first = 1'b1;
            end else begin
                m_cpu_first = 1'b0;
            end
        end else begin
            m_cpu_first = 1'b0;
            if (gd && s.d_lock) begin
                m_beats = 1;
                if (MAXB > 1) m_burst = 1'b1;
                else m_cpu_first = 1'b1;
            end
        end
    endtask

    // One full cycle: drive, sample at the falling edge against the model,
    // then step the model at the rising edge.
    task automatic runCycle(input stim_t s);
        bit gc;
        bit gd;
        logic [3:0] exp_be;
        applyStimulus(s);
        @(negedge clk);
        if (m_burst) begin
            gc = 1'b0;
            gd = s.d_req;
        end else if (s.c_req && s.d_req) begin
            gd = STARVE_ON && (m_starve >= LIMIT) && !m_cpu_first;
            gc = !gd;
        end else begin
            gc = s.c_req;
            gd = s.d_req;
        end
        exp_be = gd ? s.d_be : (gc ? s.c_be : 4'b0);
        snap_stall = cpu_stall;
        snap_dgnt  = dma_gnt;
        snap_en    = dm_en;
        snap_addr  = dm_addr;
        snap_be    = dm_byteen;
        snap_crv   = cpu_rvalid;
        snap_drv   = dma_rvalid;
        snap_rdata = rdata;
        if (s.rst_n) begin
            checkOutput("cpu_stall", cpu_stall, s.c_req && !gc);
            checkOutput("dma_gnt", dma_gnt, gd);
            checkOutput("dm_en", dm_en, gc || gd);
            checkOutput("dm_byteen", dm_byteen, exp_be);
            if (gc || gd) begin
                checkOutput("dm_addr", dm_addr, gd ? {s.d_ad[31:2], 2'b00} : {s.c_ad[31:2], 2'b00});
                checkOutput("dm_wdata", dm_wdata, gd ? s.d_wd : s.c_wd);
            end
        end
        checkOutput("cpu_rvalid", cpu_rvalid, m_pend == 1);
        checkOutput("dma_rvalid", dma_rvalid, m_pend == 2);
        if (m_pend != 0) checkOutput("rdata", rdata, s.rd);
        @(posedge clk);
        modelStep(s, gc, gd);
        #1;
    endtask

    initial begin
        int dgnt_cnt;
        int seen_gnt;
        checks   = 0;
        failures = 0;
        applyStimulus(mk(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
        modelStep(mk(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0), 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_cpu_rvalid", cpu_rvalid, 1'b0);
        checkOutput("reset_dma_rvalid", dma_rvalid, 1'b0);

        $display("[TB] CPU-only word write");
        runCycle(mk(1'b1, 1'b1, 4'hF, 32'h0000_0106, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
        checkOutput("tp_write_en", snap_en, 1'b1);
        checkOutput("tp_write_addr", snap_addr, 32'h0000_0104);
        checkOutput("tp_write_be", snap_be, 4'hF);
        checkOutput("tp_write_stall", snap_stall, 1'b0);
        runCycle(mk(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
        checkOutput("tp_write_no_rvalid", snap_crv | snap_drv, 1'b0);

        $display("[TB] CPU read then DMA read");
        runCycle(mk(1'b1, 1'b1, 4'h0, 32'h0000_0020, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
        runCycle(mk(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'hAAAA_0001));
        checkOutput("tp_rd_cpu_rvalid", snap_crv, 1'b1);
        checkOutput("tp_rd_cpu_rdata", snap_rdata, 32'hAAAA_0001);
        runCycle(mk(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'hBBBB_0002));
        checkOutput("tp_rd_dma_rvalid", snap_drv, 1'b1);
        checkOutput("tp_rd_dma_rdata", snap_rdata, 32'hBBBB_0002);

        $display("[TB] continuous contention");
        dgnt_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            runCycle(mk(1'b1, 1'b1, 4'h3, 32'h100, 1'b1, 1'b0, 4'hC, 32'h200, 32'h0));
            if (snap_dgnt) dgnt_cnt++;
            if (i == 4) checkOutput("tp_starve_stall5", snap_stall, STARVE_ON);
        end
        checkOutput("tp_starve_dma_grants", dgnt_cnt, STARVE_ON ? 2 : 0);
        runCycle(mk(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));

        $display("[TB] locked burst longer than MAX_BURST");
        dgnt_cnt = 0;
        runCycle(mk(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h300, 32'h0));
        if (snap_dgnt) dgnt_cnt++;
        for (int i = 1; i < 8; i++) begin
            runCycle(mk(1'b1, 1'b1, 4'hF, 32'h10, 1'b1, 1'b1, 4'hF, 32'h300 + 4 * i, 32'h0));
            if (snap_dgnt) dgnt_cnt++;
        end
        checkOutput("tp_burst_beats", dgnt_cnt, 8);
        runCycle(mk(1'b1, 1'b1, 4'hF, 32'h10, 1'b1, 1'b1, 4'hF, 32'h320, 32'h0));
        checkOutput("tp_burst_cpu_after", snap_stall, 1'b0);
        checkOutput("tp_burst_dma_held", snap_dgnt, 1'b0);
        runCycle(mk(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h320, 32'h0));
        checkOutput("tp_burst_resume9", snap_dgnt, 1'b1);
        runCycle(mk(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h324, 32'h0));
        checkOutput("tp_burst_resume10", snap_dgnt, 1'b1);
        runCycle(mk(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));

        $display("[TB] lock dropped on beat 3");
        runCycle(mk(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h400, 32'h0));
        runCycle(mk(1'b1, 1'b1, 4'h0, 32'h50, 1'b1, 1'b1, 4'h0, 32'h404, 32'h0));
        checkOutput("tp_lock_beat2", snap_dgnt, 1'b1);
        runCycle(mk(1'b1, 1'b1, 4'h0, 32'h50, 1'b1, 1'b0, 4'h0, 32'h408, 32'h0));
        checkOutput("tp_lock_beat3", snap_dgnt, 1'b1);
        runCycle(mk(1'b1, 1'b1, 4'h0, 32'h50, 1'b1, 1'b1, 4'h0, 32'h40C, 32'h0));
        checkOutput("tp_lock_cpu_after", snap_stall, 1'b0);
        runCycle(mk(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));

        $display("[TB] reset during burst");
        runCycle(mk(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h500, 32'h0));
        runCycle(mk(1'b0, 1'b1, 4'h0, 32'h60, 1'b1, 1'b1, 4'h0, 32'h504, 32'h0));
        runCycle(mk(1'b1, 1'b1, 4'h0, 32'h60, 1'b1, 1'b1, 4'h0, 32'h508, 32'h0));
        checkOutput("tp_rst_no_rvalid", snap_crv | snap_drv, 1'b0);
        checkOutput("tp_rst_cpu_granted", snap_stall, 1'b0);
        checkOutput("tp_rst_dma_not_granted", snap_dgnt, 1'b0);

        $display("[TB] randomized traffic");
        seen_gnt = 0;
        for (int i = 0; i < 400; i++) begin
            runCycle(mk($urandom_range(0, 59) != 0,
                        $urandom_range(0, 3) != 0,
                        ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
                        $urandom,
                        $urandom_range(0, 2) != 0,
                        $urandom_range(0, 3) != 0,
                        ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
                        $urandom,
                        $urandom));
            if (snap_dgnt) seen_gnt++;
        end
        $display("[TB] random phase DMA grants: %0d", seen_gnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
